// File: rtl/sd_arb_pkg.sv
// rtl/sd_arb_pkg.sv - shared types and constants for the SD sector arbiter
package sd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int SECTOR_BYTES = 512;
  localparam int BYTE_CNT_W   = 10;

endpackage

// File: rtl/sd_sector_arbiter_if.sv
// rtl/sd_sector_arbiter_if.sv - user_io SD-emulation channel bundle
interface sd_sector_arbiter_if;

  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic [7:0]  sd_din;
  logic        sd_ack;
  logic [7:0]  sd_dout;
  logic        sd_dout_strobe;
  logic        sd_din_strobe;

  // master: arbiter side; slave: user_io side (SPI-domain handshake)
  modport master (
    output sd_lba, sd_rd, sd_wr, sd_din,
    input  sd_ack, sd_dout, sd_dout_strobe, sd_din_strobe
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_din,
    output sd_ack, sd_dout, sd_dout_strobe, sd_din_strobe
  );

endinterface

// File: rtl/sd_arb_sync.sv
// rtl/sd_arb_sync.sv - 2-FF synchronizer with level and rise/fall detect
module sd_arb_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0],[1] are the synchronizer stages, [2] holds the previous level
  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q <= {3{RST_VAL}};
    end else begin
      sh_q <= sh_d;
    end
  end

  assign level = sh_q[1];
  assign rise  = sh_q[1] & ~sh_q[2];
  assign fall  = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/sd_sector_arbiter.sv
// rtl/sd_sector_arbiter.sv - round-robin share of the user_io SD channel; SD_ARB_TIMEOUT_EN adds an ack watchdog
module sd_sector_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NREQ           = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [32*NREQ-1:0]   req_lba,
  input  logic [8*NREQ-1:0]    req_din,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic [7:0]           dout,
  output logic [NREQ-1:0]      dout_valid,
  output logic [NREQ-1:0]      din_next,
  sd_sector_arbiter_if.master  sd
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic ack_lvl, ack_rise, ack_fall;
  logic dstb_rise, istb_rise;
  logic [3:0] unused_sync;

  // ack resets high so a reset during a live transfer cannot re-issue
  // until user_io has visibly released ack
  sd_arb_sync #(.RST_VAL(1'b1)) u_sync_ack (
    .clk(clk), .reset_n(reset_n), .d(sd.sd_ack),
    .level(ack_lvl), .rise(ack_rise), .fall(ack_fall)
  );

  sd_arb_sync #(.RST_VAL(1'b0)) u_sync_dstb (
    .clk(clk), .reset_n(reset_n), .d(sd.sd_dout_strobe),
    .level(unused_sync[0]), .rise(dstb_rise), .fall(unused_sync[1])
  );

  sd_arb_sync #(.RST_VAL(1'b0)) u_sync_istb (
    .clk(clk), .reset_n(reset_n), .d(sd.sd_din_strobe),
    .level(unused_sync[2]), .rise(istb_rise), .fall(unused_sync[3])
  );

  arb_state_e            state_q, state_d;
  logic [IDXW-1:0]       g_q, g_d;
  logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [NREQ-1:0]       done_q, done_d;
  logic [NREQ-1:0]       err_q, err_d;
  logic [NREQ-1:0]       dout_valid_q, dout_valid_d;
  logic [NREQ-1:0]       din_next_q, din_next_d;
  logic [7:0]            dout_q, dout_d;
  logic [31:0]           lba_q, lba_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  is_wr_q, is_wr_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [IDXW-1:0]       g_next;

  logic                  pick_found;
  logic [IDXW-1:0]       pick_idx;

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0]           tmo_q, tmo_d;
`else
  logic                  unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // First active requester at or after rr_ptr, walking upward with wrap
  always_comb begin : pick_comb
    int              j;
    logic [IDXW-1:0] jj;
    pick_found = 1'b0;
    pick_idx   = '0;
    j          = 0;
    jj         = '0;
    for (int k = 0; k < NREQ; k++) begin
      j  = (int'(rr_ptr_q) + k) % NREQ;
      jj = IDXW'(j);
      if (!pick_found && (req_rd[jj] || req_wr[jj])) begin
        pick_found = 1'b1;
        pick_idx   = jj;
      end
    end
  end

  assign g_next = (g_q == IDXW'(NREQ - 1)) ? '0 : g_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    err_d        = '0;
    dout_valid_d = '0;
    din_next_d   = '0;
    dout_d       = dout_q;
    lba_d        = lba_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    is_wr_d      = is_wr_q;
    byte_cnt_d   = byte_cnt_q;
`ifdef SD_ARB_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!ack_lvl && pick_found) begin
          g_d             = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          lba_d           = req_lba[{pick_idx, 5'b0} +: 32];
          rd_d            = req_rd[pick_idx];
          wr_d            = !req_rd[pick_idx];
          is_wr_d         = !req_rd[pick_idx];
          state_d         = ST_ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
          tmo_d           = '0;
`endif
        end
      end

      ST_ISSUE: begin
        if (ack_rise) begin
          rd_d       = 1'b0;
          wr_d       = 1'b0;
          byte_cnt_d = '0;
          state_d    = ST_XFER;
        end
`ifdef SD_ARB_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
          rd_d       = 1'b0;
          wr_d       = 1'b0;
          done_d[g_q] = 1'b1;
          err_d[g_q]  = 1'b1;
          state_d    = ST_DONE;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
`endif
      end

      ST_XFER: begin
        if (!is_wr_q && dstb_rise) begin
          byte_cnt_d        = byte_cnt_q + 1'b1;
          dout_d            = sd.sd_dout;
          dout_valid_d[g_q] = 1'b1;
        end
        if (is_wr_q && istb_rise) begin
          byte_cnt_d      = byte_cnt_q + 1'b1;
          din_next_d[g_q] = 1'b1;
        end
        // Use the updated count so a strobe coinciding with ack fall still counts
        if (ack_fall) begin
          done_d[g_q] = 1'b1;
          err_d[g_q]  = (byte_cnt_d != BYTE_CNT_W'(SECTOR_BYTES));
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        gnt_d    = '0;
        rr_ptr_d = g_next;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      g_q          <= '0;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      dout_valid_q <= '0;
      din_next_q   <= '0;
      dout_q       <= 8'h00;
      lba_q        <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      is_wr_q      <= 1'b0;
      byte_cnt_q   <= '0;
`ifdef SD_ARB_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      dout_valid_q <= dout_valid_d;
      din_next_q   <= din_next_d;
      dout_q       <= dout_d;
      lba_q        <= lba_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      is_wr_q      <= is_wr_d;
      byte_cnt_q   <= byte_cnt_d;
`ifdef SD_ARB_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign din_next   = din_next_q;
  assign sd.sd_lba  = lba_q;
  assign sd.sd_rd   = rd_q;
  assign sd.sd_wr   = wr_q;
  assign sd.sd_din  = req_din[{g_q, 3'b0} +: 8];

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// tb/tb_sd_sector_arbiter.sv - self-checking bench for sd_sector_arbiter
module tb_sd_sector_arbiter;

  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_rd = '0;
  logic [NREQ-1:0]   req_wr = '0;
  logic [32*NREQ-1:0] req_lba = '0;
  logic [8*NREQ-1:0] req_din = {8'h80, 8'h40};
  logic [NREQ-1:0]   gnt, done, err, dout_valid, din_next;
  logic [7:0]        dout;

  sd_sector_arbiter_if sd ();

  sd_sector_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_din(req_din),
    .gnt(gnt), .done(done), .err(err), .dout(dout),
    .dout_valid(dout_valid), .din_next(din_next), .sd(sd)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] idx; logic [7:0] data; } beat_t;
  typedef struct packed { logic [1:0] idx; logic err; } done_t;
  typedef struct {
    int          idx;
    bit          is_wr;
    logic [31:0] lba;
    int          nbytes;
    bit          exp_err;
  } vec_t;

  beat_t           exp_beats[$];
  done_t           exp_done[$];
  logic [NREQ-1:0] exp_gnt[$];
  logic [7:0]      din_model[NREQ];
  logic [NREQ-1:0] prev_gnt = '0;
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int exp_done_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pops expectations as the DUT produces output
  always @(negedge clk) begin
    beat_t b;
    done_t d;
    if (!reset_n) begin
      prev_gnt = '0;
    end else begin
      if (gnt != prev_gnt && gnt != '0) begin
        if (exp_gnt.size() == 0) check("unexpected_gnt", gnt, '0);
        else check("gnt", gnt, exp_gnt.pop_front());
      end
      prev_gnt = gnt;
      if (dout_valid != '0) begin
        if (exp_beats.size() == 0) check("unexpected_dout_valid", dout_valid, '0);
        else begin
          b = exp_beats.pop_front();
          check("dout_valid", dout_valid, oh(int'(b.idx)));
          check("dout", dout, b.data);
        end
      end
      if (din_next != '0) begin
        if (exp_beats.size() == 0) check("unexpected_din_next", din_next, '0);
        else begin
          b = exp_beats.pop_front();
          check("din_next", din_next, oh(int'(b.idx)));
          check("sd_din", sd.sd_din, b.data);
          req_din[int'(b.idx)*8 +: 8] = b.data + 8'd1;
        end
      end
      if (err & ~done) check("err_without_done", err, '0);
      if (done != '0) begin
        done_cnt++;
        if (exp_done.size() == 0) check("unexpected_done", done, '0);
        else begin
          d = exp_done.pop_front();
          check("done", done, oh(int'(d.idx)));
          check("err", err, d.err ? oh(int'(d.idx)) : '0);
        end
      end
    end
  end

  task automatic wait_issue();
    bit ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      tick();
      ok = sd.sd_rd | sd.sd_wr;
    end
    check("issue_seen", ok, 1);
  endtask

  task automatic serve(input int idx, input bit is_wr, input logic [31:0] lba,
                       input int nbytes, input bit exp_err);
    bit ok = 0;
    exp_gnt.push_back(oh(idx));
    exp_done.push_back('{idx: 2'(idx), err: exp_err});
    exp_done_total++;
    req_lba[idx*32 +: 32] = lba;
    if (is_wr) req_wr[idx] = 1'b1;
    else req_rd[idx] = 1'b1;
    wait_issue();
    check("sd_lba", sd.sd_lba, lba);
    check("sd_rd", sd.sd_rd, !is_wr);
    check("sd_wr", sd.sd_wr, is_wr);
    sd.sd_ack = 1'b1;
    for (int c = 0; c < 10 && !ok; c++) begin
      tick();
      ok = !(sd.sd_rd | sd.sd_wr);
    end
    check("cmd_drop_after_ack", ok, 1);
    // Request withdrawn after grant: the transfer must still complete
    req_rd[idx] = 1'b0;
    req_wr[idx] = 1'b0;
    for (int b = 0; b < nbytes; b++) begin
      if (is_wr) begin
        exp_beats.push_back('{idx: 2'(idx), data: din_model[idx]});
        din_model[idx] = din_model[idx] + 8'd1;
        sd.sd_din_strobe = 1'b1;
      end else begin
        sd.sd_dout = 8'(b);
        exp_beats.push_back('{idx: 2'(idx), data: 8'(b)});
        sd.sd_dout_strobe = 1'b1;
      end
      tick(); tick();
      sd.sd_din_strobe = 1'b0;
      sd.sd_dout_strobe = 1'b0;
      tick(); tick();
    end
    sd.sd_ack = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      tick();
      ok = (done_cnt >= exp_done_total);
    end
    check("done_seen", ok, 1);
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"}, gnt, '0);
    check({tag, "_done"}, done, '0);
    check({tag, "_err"}, err, '0);
    check({tag, "_dout"}, dout, 8'h00);
    check({tag, "_dout_valid"}, dout_valid, '0);
    check({tag, "_din_next"}, din_next, '0);
    check({tag, "_sd_rd"}, sd.sd_rd, 0);
    check({tag, "_sd_wr"}, sd.sd_wr, 0);
    check({tag, "_sd_lba"}, sd.sd_lba, 0);
  endtask

  initial begin
    vec_t vecs[5];
    bit   blocked;
    sd.sd_ack = 1'b0;
    sd.sd_dout = 8'h00;
    sd.sd_dout_strobe = 1'b0;
    sd.sd_din_strobe = 1'b0;
    din_model[0] = 8'h40;
    din_model[1] = 8'h80;

    vecs[0] = '{idx: 0, is_wr: 1'b0, lba: 32'h0000_0123, nbytes: 512, exp_err: 1'b0};
    vecs[1] = '{idx: 1, is_wr: 1'b1, lba: 32'h0000_ABCD, nbytes: 512, exp_err: 1'b0};
    vecs[2] = '{idx: 0, is_wr: 1'b0, lba: 32'hDEAD_BEEF, nbytes: 100, exp_err: 1'b1};
    vecs[3] = '{idx: 0, is_wr: 1'b1, lba: 32'h0000_0077, nbytes: 513, exp_err: 1'b1};
    vecs[4] = '{idx: 1, is_wr: 1'b0, lba: 32'h0000_1000, nbytes: 0,   exp_err: 1'b1};

    repeat (3) tick();
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (4) tick();

    for (int v = 0; v < 5; v++) begin
      serve(vecs[v].idx, vecs[v].is_wr, vecs[v].lba, vecs[v].nbytes, vecs[v].exp_err);
      wait_done();
    end

    // Contention: 0 wins first; re-asserted 0 must then yield to pending 1
    req_lba[31:0]  = 32'h0000_0200;
    req_lba[63:32] = 32'h0000_0300;
    req_rd[0] = 1'b1;
    req_wr[1] = 1'b1;
    serve(0, 1'b0, 32'h0000_0200, 512, 1'b0);
    req_rd[0] = 1'b1;
    serve(1, 1'b1, 32'h0000_0300, 512, 1'b0);
    serve(0, 1'b0, 32'h0000_0200, 512, 1'b0);
    wait_done();

    // Reset in the middle of a read with ack still asserted
    exp_gnt.push_back(oh(0));
    req_lba[31:0] = 32'h0000_0055;
    req_rd[0] = 1'b1;
    wait_issue();
    sd.sd_ack = 1'b1;
    repeat (4) tick();
    for (int b = 1; b <= 3; b++) begin
      sd.sd_dout = 8'(b);
      exp_beats.push_back('{idx: 2'd0, data: 8'(b)});
      sd.sd_dout_strobe = 1'b1;
      tick(); tick();
      sd.sd_dout_strobe = 1'b0;
      tick(); tick();
    end
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    tick(); tick();
    reset_n = 1'b1;
    blocked = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (sd.sd_rd || gnt != '0) blocked = 1'b0;
    end
    check("no_issue_while_ack_high", blocked, 1);
    sd.sd_ack = 1'b0;
    serve(0, 1'b0, 32'h0000_0055, 512, 1'b0);
    wait_done();

`ifdef SD_ARB_TIMEOUT_EN
    begin
      int n = 0;
      exp_gnt.push_back(oh(1));
      exp_done.push_back('{idx: 2'd1, err: 1'b1});
      exp_done_total++;
      req_lba[63:32] = 32'h0000_0999;
      req_rd[1] = 1'b1;
      wait_issue();
      while (!done[1] && n < 200) begin
        tick();
        n++;
      end
      check("timeout_cycles", n, 100);
      check("timeout_err", err[1], 1);
      check("timeout_sd_rd", sd.sd_rd, 0);
      req_rd[1] = 1'b0;
      wait_done();
    end
`endif

    repeat (4) tick();
    check("beats_left", exp_beats.size(), 0);
    check("gnts_left", exp_gnt.size(), 0);
    check("dones_left", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
